// File: rtl/peridot_config_multiboot_if.sv
// Avalon-MM link between the multiboot sequencer (master) and the device
// configuration primitive (slave).
interface peridot_config_multiboot_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/peridot_config_multiboot.sv
// N-image remote-update sequencer: reads the running image after reset, then
// selects and triggers a new image. Optional busy-poll timeout: PERIDOT_CONFIG_MB_TIMEOUT_EN.
module peridot_config_multiboot #(
    parameter int IMAGE_NUM          = 2,
    parameter int INIT_WAIT_CYCLE    = 16,
    parameter int RECONF_DELAY_CYCLE = 10,
    parameter int CUR_IMAGE_LSB      = 13,
    parameter int POLL_LIMIT         = 255,
    localparam int IMG_W = ($clog2(IMAGE_NUM) < 1) ? 1 : $clog2(IMAGE_NUM)
) (
    input  logic                      clock_sig,
    input  logic                      reset_sig,
    input  logic                      ru_nconfig,
    input  logic [IMG_W-1:0]          ru_imagesel,
    output logic                      ru_ready,
    output logic [IMG_W-1:0]          ru_image,
    output logic                      ru_nstatus,
    output logic                      ru_error,
    output logic                      cfg_nreset,
    peridot_config_multiboot_if.master avm
);

`ifdef PERIDOT_CONFIG_MB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int DELAY_W    = 27;
    localparam int POLL_CNT_W = ($clog2(POLL_LIMIT + 1) < 1) ? 1 : $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        INIT,
        REQ,
        POLL_RD,
        POLL_DATA,
        STAT_RD,
        STAT_DATA,
        IDLE,
        SEL,
        DELAY,
        TRIG,
        HALT,
        ERROR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [2:0]            nconfig_sync;
    logic [IMG_W-1:0]      imagesel_meta;
    logic [IMG_W-1:0]      imagesel_sync;
    logic                  rise;
    logic                  sel_valid;
    logic                  init_done;
    logic                  poll_at_limit;
    logic [7:0]            init_cnt;
    logic [DELAY_W-1:0]    delay_cnt;
    logic [POLL_CNT_W-1:0] poll_cnt;
    logic [IMG_W-1:0]      req_image;

    // Config inputs come from another clock domain; nconfig idles high so its chain resets to ones.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            nconfig_sync  <= 3'b111;
            imagesel_meta <= '0;
            imagesel_sync <= '0;
        end else begin
            nconfig_sync  <= {nconfig_sync[1:0], ru_nconfig};
            imagesel_meta <= ru_imagesel;
            imagesel_sync <= imagesel_meta;
        end
    end

    assign rise          = !nconfig_sync[2] && nconfig_sync[1];
    assign sel_valid     = (32'(imagesel_sync) < 32'(IMAGE_NUM));
    assign init_done     = (init_cnt == 8'(INIT_WAIT_CYCLE - 1));
    assign poll_at_limit = TIMEOUT_EN && (poll_cnt == POLL_CNT_W'(POLL_LIMIT));

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT:      if (init_done) next_state = REQ;
            REQ:       next_state = POLL_RD;
            POLL_RD:   next_state = POLL_DATA;
            POLL_DATA: begin
                if (!avm.readdata[0]) begin
                    next_state = STAT_RD;
                end else if (poll_at_limit) begin
                    next_state = ERROR;
                end else begin
                    next_state = POLL_RD;
                end
            end
            STAT_RD:   next_state = STAT_DATA;
            STAT_DATA: next_state = IDLE;
            IDLE:      if (rise && sel_valid) next_state = SEL;
            SEL:       next_state = DELAY;
            DELAY:     if (delay_cnt == '0) next_state = TRIG;
            TRIG:      next_state = HALT;
            HALT:      next_state = HALT;
            ERROR:     next_state = ERROR;
            default:   next_state = INIT;
        endcase
    end

    // Bus outputs are pure state decodes so a reset drops them without a clock edge.
    always_comb begin
        avm.read      = 1'b0;
        avm.write     = 1'b0;
        avm.address   = 3'd0;
        avm.writedata = 32'd0;
        case (state)
            REQ: begin
                avm.write     = 1'b1;
                avm.address   = 3'd2;
                avm.writedata = 32'd1;
            end
            POLL_RD, POLL_DATA: begin
                avm.read    = 1'b1;
                avm.address = 3'd3;
            end
            STAT_RD, STAT_DATA: begin
                avm.read    = 1'b1;
                avm.address = 3'd4;
            end
            SEL: begin
                avm.write     = 1'b1;
                avm.address   = 3'd1;
                avm.writedata = 32'({req_image, 1'b1});
            end
            TRIG: begin
                avm.write     = 1'b1;
                avm.address   = 3'd0;
                avm.writedata = 32'd1;
            end
            default: ;
        endcase
    end

    assign ru_ready   = (state == IDLE);
    assign ru_nstatus = ru_ready && nconfig_sync[2];

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            init_cnt   <= 8'd0;
            cfg_nreset <= 1'b0;
            poll_cnt   <= '0;
            ru_image   <= '0;
            ru_error   <= 1'b0;
            req_image  <= '0;
            delay_cnt  <= '0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 8'd1;
                if (init_done) cfg_nreset <= 1'b1;
            end
            if (state == POLL_RD && poll_cnt != POLL_CNT_W'(POLL_LIMIT)) begin
                poll_cnt <= poll_cnt + POLL_CNT_W'(1);
            end
            if (state == STAT_DATA) begin
                ru_image <= avm.readdata[CUR_IMAGE_LSB +: IMG_W];
            end
            // An out-of-range request only flags the error; the block stays ready.
            if (state == IDLE && rise) begin
                if (sel_valid) begin
                    req_image <= imagesel_sync;
                    delay_cnt <= DELAY_W'(RECONF_DELAY_CYCLE);
                end else begin
                    ru_error <= 1'b1;
                end
            end
            if (state == DELAY && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - DELAY_W'(1);
            end
            if (next_state == ERROR) ru_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_peridot_config_multiboot.sv
// Directed bench for peridot_config_multiboot with a small model of the
// configuration primitive (busy reads, status word) and a bus monitor.
`timescale 1ns/1ps
module tb_peridot_config_multiboot;
    localparam int IMAGE_NUM  = 3;
    localparam int INIT_WAIT  = 16;
    localparam int DELAY_CYC  = 10;
    localparam int POLL_LIMIT = 4;
    localparam int IMG_W      = 2;

    logic             clock_sig   = 1'b0;
    logic             reset_sig   = 1'b0;
    logic             ru_nconfig  = 1'b1;
    logic [IMG_W-1:0] ru_imagesel = '0;
    logic             ru_ready;
    logic [IMG_W-1:0] ru_image;
    logic             ru_nstatus;
    logic             ru_error;
    logic             cfg_nreset;

    int checks = 0;
    int errors = 0;

    int          busy_cfg    = 0;
    bit          busy_stuck  = 1'b0;
    logic [31:0] status_word = 32'h0;
    int          busy_left   = 0;
    bit          rd_phase    = 1'b0;

    logic [2:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int reg3_reads   = 0;
    int reg4_reads   = 0;
    int overlap_cnt  = 0;
    int idle_bad_cnt = 0;

    peridot_config_multiboot_if avm();

    peridot_config_multiboot #(
        .IMAGE_NUM         (IMAGE_NUM),
        .INIT_WAIT_CYCLE   (INIT_WAIT),
        .RECONF_DELAY_CYCLE(DELAY_CYC),
        .CUR_IMAGE_LSB     (13),
        .POLL_LIMIT        (POLL_LIMIT)
    ) dut (
        .clock_sig  (clock_sig),
        .reset_sig  (reset_sig),
        .ru_nconfig (ru_nconfig),
        .ru_imagesel(ru_imagesel),
        .ru_ready   (ru_ready),
        .ru_image   (ru_image),
        .ru_nstatus (ru_nstatus),
        .ru_error   (ru_error),
        .cfg_nreset (cfg_nreset),
        .avm        (avm)
    );

    always #5 clock_sig = ~clock_sig;

    // Primitive model: each 2-cycle read of reg 3 consumes one busy response.
    always @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            busy_left <= busy_cfg;
            rd_phase  <= 1'b0;
        end else if (avm.read && avm.address == 3'd3) begin
            if (rd_phase) begin
                if (busy_left > 0) busy_left <= busy_left - 1;
                rd_phase <= 1'b0;
            end else begin
                rd_phase <= 1'b1;
            end
        end else begin
            rd_phase <= 1'b0;
        end
    end

    assign avm.readdata = !avm.read ? 32'h0 :
                          (avm.address == 3'd3) ? {31'b0, (busy_stuck || busy_left > 0)} :
                          (avm.address == 3'd4) ? status_word : 32'h0;

    always @(posedge clock_sig) begin
        if (avm.write) begin
            wr_addr_q.push_back(avm.address);
            wr_data_q.push_back(avm.writedata);
        end
        if (avm.read && avm.address == 3'd3) reg3_reads <= reg3_reads + 1;
        if (avm.read && avm.address == 3'd4) reg4_reads <= reg4_reads + 1;
        if (avm.read && avm.write) overlap_cnt <= overlap_cnt + 1;
        if (!avm.read && !avm.write && (avm.address != 3'd0 || avm.writedata != 32'd0))
            idle_bad_cnt <= idle_bad_cnt + 1;
    end

    task automatic test_reset();
        #2 reset_sig = 1'b1;
        #1;
        checks++; if (cfg_nreset !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_nreset: got %b expected 0", cfg_nreset); end
        checks++; if (avm.write !== 1'b0 || avm.read !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw: got read=%b write=%b expected 0/0", avm.read, avm.write); end
        repeat (3) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ru_ready); end
        checks++; if (ru_image !== 2'd0) begin errors++; $display("[TB] FAIL reset_image: got %0d expected 0", ru_image); end
        checks++; if (ru_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", ru_error); end
        checks++; if (ru_nstatus !== 1'b0) begin errors++; $display("[TB] FAIL reset_nstatus: got %b expected 0", ru_nstatus); end
        checks++; if (avm.address !== 3'd0 || avm.writedata !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus: got addr=%0d data=%h expected 0/0", avm.address, avm.writedata); end
    endtask

    task automatic test_startup();
        int wr_base, r3_base, r4_base;
        busy_cfg    = 3;
        status_word = 32'h0000_4000;
        reset_sig   = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        wr_base = wr_addr_q.size();
        r3_base = reg3_reads;
        r4_base = reg4_reads;
        repeat (5) @(negedge clock_sig);
        checks++; if (ru_nstatus !== 1'b0) begin errors++; $display("[TB] FAIL init_nstatus: got %b expected 0", ru_nstatus); end
        repeat (10) @(negedge clock_sig);
        checks++; if (cfg_nreset !== 1'b0) begin errors++; $display("[TB] FAIL init_cfg_low_15: got %b expected 0", cfg_nreset); end
        @(negedge clock_sig);
        checks++; if (cfg_nreset !== 1'b1) begin errors++; $display("[TB] FAIL init_cfg_high_16: got %b expected 1", cfg_nreset); end
        repeat (10) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL startup_ready_26: got %b expected 0", ru_ready); end
        @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b1) begin errors++; $display("[TB] FAIL startup_ready_27: got %b expected 1", ru_ready); end
        checks++; if (ru_image !== 2'd2) begin errors++; $display("[TB] FAIL startup_image: got %0d expected 2", ru_image); end
        checks++; if (ru_nstatus !== 1'b1) begin errors++; $display("[TB] FAIL startup_nstatus: got %b expected 1", ru_nstatus); end
        checks++; if (wr_addr_q.size() - wr_base != 1) begin errors++; $display("[TB] FAIL startup_write_count: got %0d expected 1", wr_addr_q.size() - wr_base); end
        else begin
            checks++; if (wr_addr_q[wr_base] !== 3'd2 || wr_data_q[wr_base] !== 32'd1) begin errors++; $display("[TB] FAIL startup_req_write: got addr=%0d data=%h expected 2/1", wr_addr_q[wr_base], wr_data_q[wr_base]); end
        end
        checks++; if (reg3_reads - r3_base != 8) begin errors++; $display("[TB] FAIL startup_poll_reads: got %0d expected 8", reg3_reads - r3_base); end
        checks++; if (reg4_reads - r4_base != 2) begin errors++; $display("[TB] FAIL startup_status_reads: got %0d expected 2", reg4_reads - r4_base); end
    endtask

    task automatic test_nstatus();
        @(negedge clock_sig);
        ru_nconfig = 1'b0;
        repeat (2) @(negedge clock_sig);
        checks++; if (ru_nstatus !== 1'b1) begin errors++; $display("[TB] FAIL nstatus_hold_2: got %b expected 1", ru_nstatus); end
        @(negedge clock_sig);
        checks++; if (ru_nstatus !== 1'b0) begin errors++; $display("[TB] FAIL nstatus_follow_3: got %b expected 0", ru_nstatus); end
    endtask

    task automatic test_out_of_range();
        int wr_base;
        ru_imagesel = 2'd3;
        repeat (2) @(negedge clock_sig);
        wr_base    = wr_addr_q.size();
        ru_nconfig = 1'b1;
        repeat (2) @(negedge clock_sig);
        checks++; if (ru_error !== 1'b0) begin errors++; $display("[TB] FAIL oor_error_early: got %b expected 0", ru_error); end
        @(negedge clock_sig);
        checks++; if (ru_error !== 1'b1) begin errors++; $display("[TB] FAIL oor_error: got %b expected 1", ru_error); end
        checks++; if (ru_nstatus !== 1'b1) begin errors++; $display("[TB] FAIL oor_nstatus: got %b expected 1", ru_nstatus); end
        repeat (5) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b1) begin errors++; $display("[TB] FAIL oor_ready: got %b expected 1", ru_ready); end
        checks++; if (wr_addr_q.size() != wr_base) begin errors++; $display("[TB] FAIL oor_no_write: got %0d writes expected 0", wr_addr_q.size() - wr_base); end
    endtask

    task automatic test_reconfig();
        int found, gap, wr_base;
        ru_imagesel = 2'd2;
        repeat (2) @(negedge clock_sig);
        ru_nconfig = 1'b0;
        repeat (3) @(negedge clock_sig);
        ru_nconfig = 1'b1;
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock_sig);
            if (avm.write) begin found = i; break; end
        end
        checks++; if (found != 3) begin errors++; $display("[TB] FAIL sel_latency: got %0d expected 3", found); end
        checks++; if (avm.address !== 3'd1 || avm.writedata !== 32'h5) begin errors++; $display("[TB] FAIL sel_write: got addr=%0d data=%h expected 1/5", avm.address, avm.writedata); end
        checks++; if (ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL sel_ready: got %b expected 0", ru_ready); end
        gap = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock_sig);
            if (avm.write) begin gap = i; break; end
        end
        checks++; if (gap != DELAY_CYC + 2) begin errors++; $display("[TB] FAIL trig_gap: got %0d expected %0d", gap, DELAY_CYC + 2); end
        checks++; if (avm.address !== 3'd0 || avm.writedata !== 32'd1) begin errors++; $display("[TB] FAIL trig_write: got addr=%0d data=%h expected 0/1", avm.address, avm.writedata); end
        @(negedge clock_sig);
        checks++; if (avm.write !== 1'b0 || ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL halt_state: got write=%b ready=%b expected 0/0", avm.write, ru_ready); end
        wr_base    = wr_addr_q.size();
        ru_nconfig = 1'b0;
        repeat (4) @(negedge clock_sig);
        ru_nconfig = 1'b1;
        repeat (8) @(negedge clock_sig);
        checks++; if (wr_addr_q.size() != wr_base || ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL halt_ignores_rise: got %0d writes ready=%b expected 0/0", wr_addr_q.size() - wr_base, ru_ready); end
    endtask

    task automatic test_mid_reset();
        int wr_base, trig_seen;
        busy_cfg    = 0;
        status_word = 32'h0000_2000;
        ru_imagesel = 2'd1;
        @(negedge clock_sig);
        reset_sig = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        repeat (20) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b0) begin errors++; $display("[TB] FAIL restart_ready_20: got %b expected 0", ru_ready); end
        @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b1 || ru_image !== 2'd1) begin errors++; $display("[TB] FAIL restart_ready_21: got ready=%b image=%0d expected 1/1", ru_ready, ru_image); end
        ru_nconfig = 1'b0;
        repeat (3) @(negedge clock_sig);
        ru_nconfig = 1'b1;
        repeat (3) @(negedge clock_sig);
        checks++; if (avm.write !== 1'b1 || avm.writedata !== 32'h3) begin errors++; $display("[TB] FAIL mid_sel_write: got write=%b data=%h expected 1/3", avm.write, avm.writedata); end
        wr_base = wr_addr_q.size();
        repeat (4) @(negedge clock_sig);
        #2 reset_sig = 1'b1;
        #1;
        checks++; if (cfg_nreset !== 1'b0 || ru_image !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_regs: got cfg=%b image=%0d expected 0/0", cfg_nreset, ru_image); end
        checks++; if (avm.write !== 1'b0 || avm.read !== 1'b0 || avm.address !== 3'd0 || avm.writedata !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_bus: got r=%b w=%b a=%0d d=%h expected 0", avm.read, avm.write, avm.address, avm.writedata); end
        @(negedge clock_sig);
        reset_sig = 1'b0;
        repeat (21) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b1) begin errors++; $display("[TB] FAIL rerun_ready: got %b expected 1", ru_ready); end
        trig_seen = 0;
        for (int i = wr_base; i < wr_addr_q.size(); i++) if (wr_addr_q[i] == 3'd0) trig_seen++;
        checks++; if (trig_seen != 0) begin errors++; $display("[TB] FAIL rerun_no_trigger: got %0d expected 0", trig_seen); end
    endtask

    task automatic test_poll_timeout();
        int r3_base, r3_mid;
        busy_stuck = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        r3_base = reg3_reads;
        repeat (1000) @(negedge clock_sig);
        r3_mid = reg3_reads;
        repeat (20) @(negedge clock_sig);
        checks++; if (ru_ready !== 1'b0 || cfg_nreset !== 1'b1) begin errors++; $display("[TB] FAIL stuck_ready_cfg: got ready=%b cfg=%b expected 0/1", ru_ready, cfg_nreset); end
`ifdef PERIDOT_CONFIG_MB_TIMEOUT_EN
        checks++; if (ru_error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_error: got %b expected 1", ru_error); end
        checks++; if (reg3_reads - r3_base != 2 * POLL_LIMIT) begin errors++; $display("[TB] FAIL timeout_polls: got %0d expected %0d", reg3_reads - r3_base, 2 * POLL_LIMIT); end
        checks++; if (avm.read !== 1'b0) begin errors++; $display("[TB] FAIL timeout_bus_quiet: got %b expected 0", avm.read); end
`else
        checks++; if (ru_error !== 1'b0) begin errors++; $display("[TB] FAIL stuck_error: got %b expected 0", ru_error); end
        checks++; if (reg3_reads - r3_mid != 20) begin errors++; $display("[TB] FAIL stuck_still_polling: got %0d expected 20", reg3_reads - r3_mid); end
`endif
        busy_stuck = 1'b0;
    endtask

    task automatic test_bus_rules();
        checks++; if (overlap_cnt != 0) begin errors++; $display("[TB] FAIL bus_rw_overlap: got %0d expected 0", overlap_cnt); end
        checks++; if (idle_bad_cnt != 0) begin errors++; $display("[TB] FAIL bus_idle_zero: got %0d expected 0", idle_bad_cnt); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_nstatus();
        test_out_of_range();
        test_reconfig();
        test_mid_reset();
        test_poll_timeout();
        test_bus_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peridot_config_multiboot.md
# peridot_config_multiboot

Multi-image remote-update sequencer for PERIDOT host-bridge designs. It sits between the host bridge's asynchronous config signals and the device configuration primitive, which it drives through a simple Avalon-MM master. After reset it reads which image is currently running. On a rising edge of `ru_nconfig` it programs the requested image index (one of `IMAGE_NUM`) and triggers reconfiguration after a programmable delay. It is the N-image, error-reporting generalisation of the two-image remote update block.

## Interface
Reset `reset_sig` is asynchronous and active-high; the clock is `clock_sig`.

Parameters:
- `IMAGE_NUM`, default 2: number of selectable images, range 2..16. `IMG_W = max(1, clog2(IMAGE_NUM))`.
- `INIT_WAIT_CYCLE`, default 16: cycles `cfg_nreset` is held low after reset, range 1..255.
- `RECONF_DELAY_CYCLE`, default 10: cycles between the select write and the trigger write, range 0..2^27-1.
- `CUR_IMAGE_LSB`, default 13: LSB of the current-image field in status register 4.
- `POLL_LIMIT`, default 255: maximum number of busy-poll reads. Used only with the timeout macro.

Ports:
- `clock_sig` in 1: clock, up to 80 MHz.
- `reset_sig` in 1: asynchronous, active-high reset.
- `ru_nconfig` in 1: asynchronous reconfig request; a rising edge triggers the sequence.
- `ru_imagesel` in IMG_W: asynchronous requested image index.
- `ru_ready` out 1: status is valid and the block is idle.
- `ru_image` out IMG_W: index of the currently running image.
- `ru_nstatus` out 1: synchronised `ru_nconfig` while ready; otherwise 0.
- `ru_error` out 1: sticky error flag.
- `cfg_nreset` out 1: active-low reset to the configuration primitive.
- `avm_address` out 3, `avm_write` out 1, `avm_writedata` out 32, `avm_read` out 1: master to the primitive.
- `avm_readdata` in 32: read data from the primitive.

## Operation
- **Synchronisers:** `ru_nconfig` goes through 3 flops with reset value 111. Rise = `!s[2] && s[1]`. `ru_imagesel` goes through 2 flops with reset value 0.
- **Register map:**
  - Reg 2, write 1: request status.
  - Reg 3, bit0: busy.
  - Reg 4: status word.
  - Reg 1, write `{image, 1'b1}`: select image. Bit0 is the overwrite enable; the image index occupies bits [IMG_W:1]; all other bits are 0.
  - Reg 0, write 1: reconfig trigger.
- **States:**
  - INIT: counter increments. When it reaches `INIT_WAIT_CYCLE`, `cfg_nreset` goes to 1 and stays 1 until reset; next state is REQ.
  - REQ: write reg 2 with data 1 for one cycle; next is POLL_RD.
  - POLL_RD: read reg 3; next is POLL_DATA.
  - POLL_DATA: read reg 3 and sample `avm_readdata[0]`. If 1, go to POLL_RD; if 0, go to STAT_RD.
  - STAT_RD: read reg 4; next is STAT_DATA.
  - STAT_DATA: read reg 4 and latch `ru_image <= avm_readdata[CUR_IMAGE_LSB +: IMG_W]`. Set `ru_ready`; next is IDLE.
  - IDLE: on rise, sample the synchronised `ru_imagesel`.
    - Index < `IMAGE_NUM`: latch it, clear `ru_ready`, load the delay counter with `RECONF_DELAY_CYCLE`, go to SEL.
    - Index out of range: set `ru_error`, stay in IDLE with `ru_ready` unchanged.
  - SEL: write reg 1 with `{image, 1'b1}` for one cycle; next is DELAY.
  - DELAY: if the counter is 0, go to TRIG; else decrement the counter.
  - TRIG: write reg 0 with data 1 for one cycle; next is HALT.
  - HALT: terminal state; only reset leaves it.
  - ERROR: terminal state. `ru_ready` = 0, `ru_error` = 1.
- **Idle master outputs:** `avm_address` and `avm_writedata` are 0 whenever the block is not in an access state. `avm_read` and `avm_write` are never high in the same cycle.
- **Ignored edges:** rises of `ru_nconfig` outside IDLE are ignored, including during INIT/poll and DELAY. A request of the same index as `ru_image` is still executed.
- **Mid-operation reset:** all state returns to reset values immediately, including dropping `avm_write`.

## Timing
- Reset values:
  - `ru_ready` = 0, `ru_image` = 0, `ru_error` = 0.
  - `ru_nstatus` = 0, `cfg_nreset` = 0.
  - `avm_read` = 0, `avm_write` = 0, `avm_address` = 0, `avm_writedata` = 0.
  - State = INIT.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- **Reads:** each read holds `avm_read` for 2 cycles (RD, DATA). `avm_readdata` is sampled on the second cycle, so the primitive has a fixed read latency of 1.
- **Startup latency, no busy:** `INIT_WAIT_CYCLE` + 1 (REQ) + 2 (poll) + 2 (status) cycles to `ru_ready` = 1.
- **Reconfig latency:** from a synchronised rise seen in IDLE to the TRIG write is 1 (SEL) + `RECONF_DELAY_CYCLE` + 1 cycles. The input synchroniser adds 2–3 cycles from the pin.
- `ru_nstatus` follows `s[2]` combinationally through the `ru_ready` gate.

## Configuration
- `PERIDOT_CONFIG_MB_TIMEOUT_EN` defined:
  - POLL_RD entries are counted.
  - If a busy read returns 1 when the count equals `POLL_LIMIT`, go to ERROR.
  - `cfg_nreset` stays 1 and no further accesses are issued.
- `PERIDOT_CONFIG_MB_TIMEOUT_EN` undefined:
  - Busy polling continues indefinitely.
  - ERROR is unreachable; `ru_error` is set only by an out-of-range select.

## Test plan
- **Startup:** `IMAGE_NUM`=4; reg 3 busy for 3 reads; reg 4 = 0x0000_4000 → `ru_image` = 2, `ru_ready` = 1 at cycle 16+1+8+2.
- **Reconfig:** in IDLE, `ru_imagesel` = 3, raise `ru_nconfig` → write reg 1 data 0x7, then after 10 delay cycles write reg 0 data 1, then HALT with `ru_ready` = 0.
- **Out of range:** `IMAGE_NUM`=3, `ru_imagesel` = 3, raise `ru_nconfig` → no bus write, `ru_error` = 1, `ru_ready` stays 1.
- **Timeout:** with the macro, busy stuck at 1 and `POLL_LIMIT` = 4 → ERROR after the 4th busy poll, `ru_ready` = 0, `ru_error` = 1. Without the macro → still polling after 1000 cycles.
- **Mid-operation reset:** assert `reset_sig` in DELAY → all outputs reach reset values without waiting for a clock edge, then the sequence reruns from INIT.
- **`ru_nstatus` mirroring:** while ready, toggle `ru_nconfig` → `ru_nstatus` follows after 3 cycles; `ru_nstatus` = 0 during INIT.
